// File: rtl/spi_master_core.sv
// SPI mode-0 master engine: one word of up to DATA_W bits per transaction, full duplex,
// programmable SCLK half-period. Optional LSB-first ordering under `SPI_LSB_FIRST_EN.
module spi_master_core #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 16,
  localparam int LEN_W = $clog2(DATA_W + 1)
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              start,
  input  logic [LEN_W-1:0]  data_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W-1:0]  bits_left_q, bits_left_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_q, lsb_d;
  logic [LEN_W-1:0]  len_q, len_d;
`endif

  logic [LEN_W-1:0]  len_clamp;
  logic [LEN_W-1:0]  start_shift;
  logic [DATA_W-1:0] tx_msb_init;
  logic              phase_zero;

  // MSB-first TX is left-aligned at start so the first bit always sits in the top position.
  always_comb begin
    len_clamp   = (data_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : data_len;
    start_shift = LEN_W'(DATA_W) - len_clamp;
    tx_msb_init = wr_data << start_shift;
    phase_zero  = (phase_q == '0);
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    div_d       = div_q;
    bits_left_d = bits_left_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_d        = rd_q;
    busy_d      = busy_q;
    done_d      = done_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
`ifdef SPI_LSB_FIRST_EN
    lsb_d       = lsb_q;
    len_d       = len_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_clamp != '0) begin
            div_d       = clk_div;
            phase_d     = clk_div;
            bits_left_d = len_clamp;
            rx_d        = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            cs_n_d      = 1'b0;
            state_d     = S_LOW;
`ifdef SPI_LSB_FIRST_EN
            lsb_d       = lsb_first;
            len_d       = len_clamp;
            if (lsb_first) begin
              tx_d   = wr_data;
              mosi_d = wr_data[0];
            end else begin
              tx_d   = tx_msb_init;
              mosi_d = tx_msb_init[DATA_W-1];
            end
`else
            tx_d        = tx_msb_init;
            mosi_d      = tx_msb_init[DATA_W-1];
`endif
          end else begin
            // Zero-length request completes immediately without touching the bus.
            done_d = 1'b1;
            rd_d   = '0;
          end
        end
      end
      S_LOW: begin
        if (phase_zero) begin
          phase_d = div_q;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
`ifdef SPI_LSB_FIRST_EN
          rx_d    = lsb_q ? {spi_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso};
`else
          rx_d    = {rx_q[DATA_W-2:0], spi_miso};
`endif
        end else begin
          phase_d = phase_q - DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_zero) begin
          phase_d     = div_q;
          sclk_d      = 1'b0;
          bits_left_d = bits_left_q - LEN_W'(1);
          if (bits_left_q > LEN_W'(1)) begin
            state_d = S_LOW;
`ifdef SPI_LSB_FIRST_EN
            if (lsb_q) begin
              tx_d   = tx_q >> 1;
              mosi_d = tx_q[1];
            end else begin
              tx_d   = tx_q << 1;
              mosi_d = tx_q[DATA_W-2];
            end
`else
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[DATA_W-2];
`endif
          end else begin
            state_d = S_TRAIL;
          end
        end else begin
          phase_d = phase_q - DIV_W'(1);
        end
      end
      S_TRAIL: begin
        if (phase_zero) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
`ifdef SPI_LSB_FIRST_EN
          // LSB-first RX fills from the top; realign so bit k lands in rd_data[k].
          rd_d    = lsb_q ? (rx_q >> (LEN_W'(DATA_W) - len_q)) : rx_q;
`else
          rd_d    = rx_q;
`endif
        end else begin
          phase_d = phase_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      div_q       <= '0;
      bits_left_q <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q       <= 1'b0;
      len_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      div_q       <= div_d;
      bits_left_q <= bits_left_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_q        <= rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
`ifdef SPI_LSB_FIRST_EN
      lsb_q       <= lsb_d;
      len_q       <= len_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sclk  = sclk_q;
  assign spi_mosi  = mosi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: vector table of full transactions plus hand-written
// sequences for zero length, reset mid-transfer and (with SPI_LSB_FIRST_EN) LSB-first order.
`timescale 1ns/1ps
module tb_spi_master_core;
  localparam int DATA_W = 32;
  localparam int DIV_W  = 16;
  localparam int LEN_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  data_len = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DIV_W-1:0]  clk_div = '0;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif
  logic              busy, done, spi_cs_n, spi_sclk, spi_mosi;
  logic              spi_miso;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        dbg_state;

  spi_master_core #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .start(start),
    .data_len(data_len),
    .wr_data(wr_data),
    .clk_div(clk_div),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .busy(busy),
    .done(done),
    .rd_data(rd_data),
    .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // slave model: loopback, or shifts slave_word out MSB-first, one bit per SCLK rise
  logic              loopback = 1'b1;
  logic [DATA_W-1:0] slave_word = '0;
  int                slave_len = 0;
  int                rise_cnt = 0;
  int                s_idx;

  always @(posedge spi_sclk or negedge spi_cs_n) begin
    if (spi_sclk) rise_cnt <= rise_cnt + 1;
    else          rise_cnt <= 0;
  end

  always_comb begin
    s_idx = slave_len - 1 - rise_cnt;
    if (loopback)                        spi_miso = spi_mosi;
    else if (s_idx >= 0 && s_idx < 32)   spi_miso = slave_word[s_idx];
    else                                 spi_miso = 1'b0;
  end

  // bus monitor, samples on the falling clock edge; counters are free-running
  int                cs_low_cnt = 0, rise_seen = 0, hi_run = 0, hi_bad = 0, viol = 0;
  int                exp_h = 1;
  logic [DATA_W-1:0] mosi_word = '0;
  logic              p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;
  logic [DATA_W-1:0] p_rd = '0;

  always @(negedge clk) begin
    if (!spi_cs_n) cs_low_cnt++;
    if (spi_sclk && !p_sclk) begin
      rise_seen++;
      mosi_word = {mosi_word[DATA_W-2:0], spi_mosi};
    end
    if (spi_sclk) hi_run++;
    else begin
      if (p_sclk && hi_run != exp_h) hi_bad++;
      hi_run = 0;
    end
    if (busy != !spi_cs_n) viol++;
    if (spi_sclk && spi_cs_n) viol++;
    if (spi_mosi != p_mosi && !(p_sclk && !spi_sclk) && spi_cs_n == p_cs) viol++;
    if (busy && p_busy && rd_data != p_rd) viol++;
    p_sclk = spi_sclk;
    p_cs   = spi_cs_n;
    p_mosi = spi_mosi;
    p_busy = busy;
    p_rd   = rd_data;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wr;
    logic [DIV_W-1:0]  div;
    bit                loop;
    logic [DATA_W-1:0] sw;
    int                slen;
    int                dup_at;
    logic [DATA_W-1:0] exp_rd;
    int                exp_cs;
    int                exp_rises;
    logic [DATA_W-1:0] exp_mosi;
  } vec_t;

  vec_t vecs[7];

  // full transaction driver with checks; dup_at>0 fires an extra start that many cycles in
  task automatic run_txn(input string tag, input vec_t v);
    int                b_cs, b_rise, b_hb, b_viol, k;
    bit                got;
    logic [DATA_W-1:0] mask;
    tick();
    data_len   = v.len;
    wr_data    = v.wr;
    clk_div    = v.div;
    loopback   = v.loop;
    slave_word = v.sw;
    slave_len  = v.slen;
    exp_h      = 32'(v.div) + 1;
    b_cs = cs_low_cnt; b_rise = rise_seen; b_hb = hi_bad; b_viol = viol;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " done_cleared"}, 32'(done), 32'd0);
    check({tag, " busy_cycle1"}, 32'(busy), 32'd1);
    k   = 1;
    got = 1'b0;
    while (!got && k < 3000) begin
      if (done) got = 1'b1;
      else begin
        if (v.dup_at > 0 && k == v.dup_at) begin
          data_len = 6'd8;
          wr_data  = 32'h0000_1234;
          clk_div  = '0;
          start    = 1'b1;
          tick();
          start = 1'b0;
          k++;
          check({tag, " done_after_dup"}, 32'(done), 32'd0);
        end else begin
          tick();
          k++;
        end
      end
    end
    check({tag, " completed"}, 32'(got), 32'd1);
    check({tag, " done_cycle"}, 32'(k), 32'(v.exp_cs + 1));
    check({tag, " rd_data"}, rd_data, v.exp_rd);
    check({tag, " cs_low_cycles"}, 32'(cs_low_cnt - b_cs), 32'(v.exp_cs));
    check({tag, " sclk_rises"}, 32'(rise_seen - b_rise), 32'(v.exp_rises));
    mask = (v.exp_rises >= 32) ? '1 : ((32'd1 << v.exp_rises) - 32'd1);
    check({tag, " mosi_bits"}, mosi_word & mask, v.exp_mosi);
    check({tag, " sclk_high_len"}, 32'(hi_bad - b_hb), 32'd0);
    check({tag, " protocol"}, 32'(viol - b_viol), 32'd0);
    check({tag, " state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic zero_len(input string tag);
    int lows;
    tick();
    data_len = '0;
    wr_data  = 32'hFFFF_FFFF;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " rd_zero"}, rd_data, 32'd0);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (!spi_cs_n || busy || spi_sclk) lows++;
      tick();
    end
    check({tag, " bus_quiet"}, 32'(lows), 32'd0);
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rise, w;
    //                len     wr            div   loop sw            slen dup rd            cs   rises mosi
    vecs[0] = '{6'd8,  32'h0000_00A5, 16'd0, 1, 32'h0,         8,  0, 32'h0000_00A5, 17,  8,  32'h0000_00A5};
    vecs[1] = '{6'd32, 32'hDEAD_BEEF, 16'd3, 0, 32'h1234_5678, 32, 0, 32'h1234_5678, 260, 32, 32'hDEAD_BEEF};
    vecs[2] = '{6'd4,  32'hFFFF_FFF6, 16'd1, 1, 32'h0,         4,  0, 32'h0000_0006, 18,  4,  32'h0000_0006};
    vecs[3] = '{6'd1,  32'h0000_0001, 16'd0, 0, 32'h0,         1,  0, 32'h0000_0000, 3,   1,  32'h0000_0001};
    vecs[4] = '{6'd40, 32'h8000_0001, 16'd2, 1, 32'h0,         32, 0, 32'h8000_0001, 195, 32, 32'h8000_0001};
    vecs[5] = '{6'd5,  32'h0000_0013, 16'd0, 0, 32'h0000_001F, 5,  0, 32'h0000_001F, 11,  5,  32'h0000_0013};
    vecs[6] = '{6'd16, 32'h0000_BEEF, 16'd1, 1, 32'h0,         16, 5, 32'h0000_BEEF, 66,  16, 32'h0000_BEEF};

    repeat (3) tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst rd_data", rd_data, 32'd0);
    check("rst cs_n", 32'(spi_cs_n), 32'd1);
    check("rst sclk", 32'(spi_sclk), 32'd0);
    check("rst mosi", 32'(spi_mosi), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

    // reset in the middle of bit 4 of an 8-bit transfer
    tick();
    data_len = 6'd8; wr_data = 32'h0000_00C3; clk_div = '0; loopback = 1'b1; exp_h = 1;
    b_rise = rise_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (rise_seen - b_rise < 4 && w < 100) begin
      tick();
      w++;
    end
    check("midrst reached_bit4", 32'(rise_seen - b_rise), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst cs_n", 32'(spi_cs_n), 32'd1);
    check("midrst sclk", 32'(spi_sclk), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst rd_data", rd_data, 32'd0);
    check("midrst state", 32'(dbg_state), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    zero_len("len0_after_reset");
    run_txn("post_reset", vecs[0]);
    zero_len("len0_after_data");

`ifdef SPI_LSB_FIRST_EN
    lsb_first = 1'b1;
    run_txn("lsb_first", '{6'd4, 32'h0000_0001, 16'd0, 1, 32'h0, 4, 0,
                           32'h0000_0001, 9, 4, 32'h0000_0008});
    lsb_first = 1'b0;
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
